approx_wallace_mult_pipe: RTL



---
 rtl/approx_wallace_mult_pipe.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/approx_wallace_mult_pipe.sv
// approx_wallace_mult_pipe
// Three-stage pipelined unsigned WIDTH x WIDTH multiplier. It can compute each
// beat exactly or approximately. In approximate mode, the APPROX_COLS
// least-significant product columns are OR-reduced and carry nothing. The
// columns above them are summed exactly.
//   S1: operand/mode register; partial products come from the S1 registers
//   S2: Wallace carry-save reduction to two rows (low-column ORs land here)
//   S3: final carry-propagate add, registered to out_p
// Optional build macro APPROX_ERR_STATS_EN adds err_sum/err_cnt. These are
// saturating error statistics taken over approximate output transfers.
module approx_wallace_mult_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_approx
`ifdef APPROX_ERR_STATS_EN
    ,
    output logic [31:0]        err_sum,
    output logic [15:0]        err_cnt
`endif
);

    localparam int PW     = 2 * WIDTH;
    localparam int ROWS   = WIDTH + 1;             // WIDTH pp rows + OR row
    localparam int ARR    = 3 * ((ROWS + 2) / 3);  // padded to whole 3:2 groups
    localparam int LEVELS = 8;                     // enough for 18 rows -> 2

    // Handshake: a beat moves on an interface when valid && ready. A stage
    // loads when it is empty or its content leaves this cycle, so bubbles
    // collapse. in_ready is combinational from out_ready through this chain.
    logic s1_load, s2_load, s3_load;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic             s1_approx_q, s1_approx_d;

    logic             s2_valid_q, s2_valid_d;
    logic [PW-1:0]    s2_sum_q, s2_sum_d, s2_carry_q, s2_carry_d;
    logic             s2_approx_q, s2_approx_d;

    logic             s3_valid_q, s3_valid_d;
    logic [PW-1:0]    s3_p_q, s3_p_d;
    logic             s3_approx_q, s3_approx_d;

    logic [PW-1:0]    red_sum, red_carry;

    // Stage-advance chain from the output back to the input
    always_comb begin
        s3_load = !s3_valid_q || out_ready;
        s2_load = !s2_valid_q || s3_load;
        s1_load = !s1_valid_q || s2_load;
    end

    assign in_ready   = s1_load;
    assign out_valid  = s3_valid_q;
    assign out_p      = s3_p_q;
    assign out_approx = s3_approx_q;

    // Partial products from S1 and layered 3:2 reduction down to two rows
    always_comb begin : wallace_reduce
        logic [PW-1:0] rows [ARR];
        logic [PW-1:0] nxt  [ARR];
        logic [PW-1:0] lo;
        logic          pp;
        lo = '0;
        pp = 1'b0;
        for (int r = 0; r < ARR; r++) begin
            rows[r] = '0;
            nxt[r]  = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp = s1_a_q[i] & s1_b_q[j];
                if (s1_approx_q && ((i + j) < APPROX_COLS))
                    lo[i+j] = lo[i+j] | pp;
                else
                    rows[i][i+j] = pp;
            end
        end
        // The OR row holds one bit per low column, so it never creates a carry
        // there. The masked pp rows are zero in those columns.
        rows[WIDTH] = lo;
        for (int l = 0; l < LEVELS; l++) begin
            for (int r = 0; r < ARR; r++) nxt[r] = '0;
            for (int g = 0; g < ARR / 3; g++) begin
                nxt[2*g]   = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
                nxt[2*g+1] = ((rows[3*g] & rows[3*g+1]) |
                              (rows[3*g] & rows[3*g+2]) |
                              (rows[3*g+1] & rows[3*g+2])) << 1;
            end
            for (int r = 0; r < ARR; r++) rows[r] = nxt[r];
        end
        red_sum   = rows[0];
        red_carry = rows[1];
    end

    // Next-state for the three stage registers
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_approx_d = s1_approx_q;
        s2_valid_d  = s2_valid_q;
        s2_sum_d    = s2_sum_q;
        s2_carry_d  = s2_carry_q;
        s2_approx_d = s2_approx_q;
        s3_valid_d  = s3_valid_q;
        s3_p_d      = s3_p_q;
        s3_approx_d = s3_approx_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d      = in_a;
                s1_b_d      = in_b;
                s1_approx_d = in_approx;
            end
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_d    = red_sum;
                s2_carry_d  = red_carry;
                s2_approx_d = s1_approx_q;
            end
        end
        if (s3_load) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_p_d      = s2_sum_q + s2_carry_q;
                s3_approx_d = s2_approx_q;
            end
        end
    end

    // Pipeline registers; reset drops every in-flight beat at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_approx_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_sum_q    <= '0;
            s2_carry_q  <= '0;
            s2_approx_q <= 1'b0;
            s3_valid_q  <= 1'b0;
            s3_p_q      <= '0;
            s3_approx_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_approx_q <= s1_approx_d;
            s2_valid_q  <= s2_valid_d;
            s2_sum_q    <= s2_sum_d;
            s2_carry_q  <= s2_carry_d;
            s2_approx_q <= s2_approx_d;
            s3_valid_q  <= s3_valid_d;
            s3_p_q      <= s3_p_d;
            s3_approx_q <= s3_approx_d;
        end
    end

`ifdef APPROX_ERR_STATS_EN
    logic [WIDTH-1:0] s2_a_q, s2_a_d, s2_b_q, s2_b_d;
    logic [PW-1:0]    s3_exact_q, s3_exact_d;
    logic [31:0]      err_sum_q, err_sum_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [PW-1:0]    err_diff;
    logic [32:0]      sum_ext;

    // Operands shadow the datapath so S3 holds the exact product beside out_p
    always_comb begin
        s2_a_d     = s2_a_q;
        s2_b_d     = s2_b_q;
        s3_exact_d = s3_exact_q;
        if (s2_load && s1_valid_q) begin
            s2_a_d = s1_a_q;
            s2_b_d = s1_b_q;
        end
        if (s3_load && s2_valid_q)
            s3_exact_d = PW'(s2_a_q) * PW'(s2_b_q);
    end

    // Saturating error accumulation on approximate output transfers
    always_comb begin
        err_diff  = s3_exact_q - s3_p_q;
        sum_ext   = {1'b0, err_sum_q} + 33'(err_diff);
        err_sum_d = err_sum_q;
        err_cnt_d = err_cnt_q;
        if (s3_valid_q && out_ready && s3_approx_q) begin
            err_sum_d = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
            if ((err_diff != '0) && (err_cnt_q != 16'hFFFF))
                err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_a_q     <= '0;
            s2_b_q     <= '0;
            s3_exact_q <= '0;
            err_sum_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            s2_a_q     <= s2_a_d;
            s2_b_q     <= s2_b_d;
            s3_exact_q <= s3_exact_d;
            err_sum_q  <= err_sum_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_sum = err_sum_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule
